// File: rtl/lfsr_descrambler6_pkg.sv
// Shared definitions for the 6-bit additive scrambler/descrambler pair.
// lfsr6_next is the single source of truth for the sequence on both link ends.
package lfsr_descrambler6_pkg;

    localparam int unsigned WORD_W = 6;
    localparam int unsigned LFSR_W = 6;
    localparam int unsigned TAP_HI = 5;
    localparam int unsigned TAP_LO = 0;

    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 6'b000001;
    localparam logic [LFSR_W-1:0] LFSR_ZERO_REMAP   = 6'b000001;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [LFSR_W-1:0] lfsr_t;

    // Fibonacci step for x^6+x^5+1, period 63.
    function automatic lfsr_t lfsr6_next(input lfsr_t s);
        return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr6_gen.sv
// LFSR sequence register with load, advance and implicit hold.
// A zero seed is remapped so the register can never lock up at all-zeros.
module lfsr6_gen
    import lfsr_descrambler6_pkg::*;
#(
    parameter lfsr_t RESET_SEED = LFSR_DEFAULT_SEED
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  load,
    input  lfsr_t seed,
    input  logic  advance,
    output lfsr_t state
);

    lfsr_t seed_safe;

    assign seed_safe = (seed == '0) ? LFSR_ZERO_REMAP : seed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RESET_SEED;
        end else if (load) begin
            state <= seed_safe;
        end else if (advance) begin
            state <= lfsr6_next(state);
        end
    end

endmodule

// File: rtl/xor6.sv
// Existing 6-bit bitwise XOR block used on the descrambler data path.
module xor6 (
    input  logic [5:0] a,
    input  logic [5:0] b,
    output logic [5:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/lfsr_descrambler6.sv
// Receive-side 6-bit additive descrambler with valid/ready flow control and a registered output.
// Optional sticky parity checker is enabled with DESCR_PARITY_EN.
module lfsr_descrambler6
    import lfsr_descrambler6_pkg::*;
#(
    parameter lfsr_t       DEFAULT_SEED = LFSR_DEFAULT_SEED,
    parameter int unsigned CNT_WRAP     = 62
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [5:0]        word_cnt
`ifdef DESCR_PARITY_EN
    ,
    input  logic              in_parity,
    output logic              parity_err
`endif
);

    logic  accept;
    lfsr_t lfsr_state;
    word_t descr_word;

    // Seed load blocks acceptance so load and advance never collide.
    assign in_ready = ~seed_load & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    lfsr6_gen #(
        .RESET_SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (seed_load),
        .seed    (seed),
        .advance (accept),
        .state   (lfsr_state)
    );

    xor6 u_xor (
        .a (in_data),
        .b (lfsr_state),
        .y (descr_word)
    );

    // Output register: load on accept, clear once drained, hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= descr_word;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt <= '0;
        end else if (seed_load) begin
            word_cnt <= '0;
        end else if (accept) begin
            word_cnt <= (word_cnt == 6'(CNT_WRAP)) ? 6'd0 : word_cnt + 6'd1;
        end
    end

`ifdef DESCR_PARITY_EN
    logic parity_bad;

    // Even parity: the XOR of data and parity bit must be zero.
    assign parity_bad = ^{in_data, in_parity};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err <= 1'b0;
        end else if (seed_load) begin
            parity_err <= 1'b0;
        end else if (accept && parity_bad) begin
            parity_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_descrambler6.sv
// Directed testbench for lfsr_descrambler6; parity checks compile in with DESCR_PARITY_EN.
module tb_lfsr_descrambler6;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       seed_load;
    logic [5:0] seed;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_data;
    logic [5:0] word_cnt;
`ifdef DESCR_PARITY_EN
    logic       in_parity;
    logic       parity_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] m_s;
    logic [5:0] m_cnt;
    logic [5:0] exp_out;
    logic [5:0] orig [200];
    logic [5:0] scr  [200];

    always #5 clk = ~clk;

    lfsr_descrambler6 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seed_load (seed_load),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .word_cnt  (word_cnt)
`ifdef DESCR_PARITY_EN
        ,
        .in_parity  (in_parity),
        .parity_err (parity_err)
`endif
    );

    function automatic logic [5:0] ref_next(input logic [5:0] s);
        return {s[4:0], s[5] ^ s[0]};
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model step for one accepted word; yields the expected descrambled value.
    task automatic model_accept(input logic [5:0] data);
        exp_out = data ^ m_s;
        m_s     = ref_next(m_s);
        m_cnt   = (m_cnt == 6'd62) ? 6'd0 : m_cnt + 6'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_s   = 6'b000001;
        m_cnt = 6'd0;
    endtask

    initial begin
        reset_n   = 1'b0;
        seed_load = 1'b0;
        seed      = 6'h00;
        in_valid  = 1'b0;
        in_data   = 6'h00;
        out_ready = 1'b1;
`ifdef DESCR_PARITY_EN
        in_parity = 1'b0;
`endif
        m_s   = 6'b000001;
        m_cnt = 6'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", {5'd0, out_valid}, 6'd0);
        check("rst_out_data", out_data, 6'h00);
        check("rst_word_cnt", word_cnt, 6'd0);
        check("rst_in_ready", {5'd0, in_ready}, 6'd1);
        reset_n = 1'b1;

        // 6'h2A twice: lfsr 01 then 03
        in_valid = 1'b1;
        in_data  = 6'h2A;
        @(negedge clk);
        check("first_valid", {5'd0, out_valid}, 6'd1);
        check("first_data", out_data, 6'h2B);
        check("first_cnt", word_cnt, 6'd1);
        @(negedge clk);
        check("second_data", out_data, 6'h29);
        check("second_cnt", word_cnt, 6'd2);
        in_valid = 1'b0;
        @(negedge clk);
        check("clear_valid", {5'd0, out_valid}, 6'd0);
        check("clear_cnt", word_cnt, 6'd2);

        // Back-pressure: lfsr now 07
        in_valid = 1'b1;
        in_data  = 6'h00;
        @(negedge clk);
        check("bp_pre_data", out_data, 6'h07);
        check("bp_pre_cnt", word_cnt, 6'd3);
        out_ready = 1'b0;
        in_data   = 6'h3F;
        #1;
        check("bp_in_ready_low", {5'd0, in_ready}, 6'd0);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_data", out_data, 6'h07);
            check("bp_hold_cnt", word_cnt, 6'd3);
            check("bp_hold_valid", {5'd0, out_valid}, 6'd1);
            check("bp_hold_ready", {5'd0, in_ready}, 6'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {5'd0, in_ready}, 6'd1);
        @(negedge clk);
        check("bp_resume0_data", out_data, 6'h30);
        check("bp_resume0_cnt", word_cnt, 6'd4);
        in_data = 6'h15;
        @(negedge clk);
        check("bp_resume1_data", out_data, 6'h0A);
        check("bp_resume1_cnt", word_cnt, 6'd5);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_drain_valid", {5'd0, out_valid}, 6'd0);

        // Seed load with zero seed while in_valid is high
        seed_load = 1'b1;
        seed      = 6'h00;
        in_valid  = 1'b1;
        in_data   = 6'h00;
        #1;
        check("seed_in_ready", {5'd0, in_ready}, 6'd0);
        @(negedge clk);
        seed_load = 1'b0;
        check("seed_cnt", word_cnt, 6'd0);
        check("seed_no_accept", {5'd0, out_valid}, 6'd0);
        @(negedge clk);
        check("seed_zero_remap", out_data, 6'h01);
        check("seed_next_cnt", word_cnt, 6'd1);
        in_valid = 1'b0;

        // 63 accepts from reset: counter wraps and sequence repeats
        do_reset();
        in_valid = 1'b1;
        in_data  = 6'h00;
        for (int i = 0; i < 63; i++) begin
            @(negedge clk);
            model_accept(6'h00);
            check("wrap_seq_data", out_data, exp_out);
            check("wrap_seq_cnt", word_cnt, m_cnt);
            if (i == 5) check("wrap_seq_s5", out_data, 6'h3F);
            if (i == 6) check("wrap_seq_s6", out_data, 6'h3E);
            if (i == 61) check("wrap_cnt_62", word_cnt, 6'd62);
            if (i == 62) check("wrap_cnt_0", word_cnt, 6'd0);
        end
        @(negedge clk);
        check("wrap_lfsr_back", out_data, 6'h01);
        check("wrap_cnt_1", word_cnt, 6'd1);
        in_valid = 1'b0;
        @(negedge clk);

        // Loopback against a reference scrambler seeded 6'h15
        m_s = 6'h15;
        for (int i = 0; i < 200; i++) begin
            orig[i] = 6'($urandom_range(63, 0));
            scr[i]  = orig[i] ^ m_s;
            m_s     = ref_next(m_s);
        end
        seed_load = 1'b1;
        seed      = 6'h15;
        @(negedge clk);
        seed_load = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in_data = scr[i];
            @(negedge clk);
            check("loop_data", out_data, orig[i]);
            check("loop_valid", {5'd0, out_valid}, 6'd1);
        end
        check("loop_cnt", word_cnt, 6'(200 % 63));
        in_valid = 1'b0;
        @(negedge clk);

        // Async reset mid-cycle while a word is pending
        in_valid = 1'b1;
        in_data  = 6'h2A;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("arst_pre_valid", {5'd0, out_valid}, 6'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", {5'd0, out_valid}, 6'd0);
        check("arst_data", out_data, 6'h00);
        check("arst_cnt", word_cnt, 6'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;

`ifdef DESCR_PARITY_EN
        // Sticky parity error, cleared only by seed_load
        check("par_rst", {5'd0, parity_err}, 6'd0);
        in_valid  = 1'b1;
        in_data   = 6'h03;
        in_parity = 1'b0;
        @(negedge clk);
        check("par_good", {5'd0, parity_err}, 6'd0);
        in_data   = 6'h01;
        in_parity = 1'b0;
        @(negedge clk);
        check("par_bad", {5'd0, parity_err}, 6'd1);
        in_data   = 6'h01;
        in_parity = 1'b1;
        @(negedge clk);
        check("par_sticky", {5'd0, parity_err}, 6'd1);
        in_valid  = 1'b0;
        seed_load = 1'b1;
        seed      = 6'h01;
        @(negedge clk);
        seed_load = 1'b0;
        check("par_cleared", {5'd0, parity_err}, 6'd0);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
